// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl
// -----------------------------------------------------------------------------
// Sequencer for a fully-connected layer datapath. A job loads three byte
// buffers over one input stream: the input vector, then the weights, then the
// bias. It pulses the datapath enable, waits for the datapath result, and
// streams the result bytes out.
//
// Ports
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   start                     : job request, only looked at in IDLE
//   cfg_in_size, cfg_out_size : job vector lengths, captured together with start
//   s_data/s_valid/s_ready    : byte load stream (input side)
//   fc_en                     : one-cycle enable to the datapath
//   fc_actual_in/_out         : latched job sizes for the datapath
//   fc_in_vec/fc_weights/fc_bias : packed buffers, byte k at bits [k*8 +: 8]
//   fc_out_vec, fc_valid      : datapath result and its strobe
//   m_data/m_valid/m_ready    : result byte stream (output side)
//   busy, done, err           : job active / completion pulse / config error pulse
//   o_dbg_state               : current FSM state (IDLE=0 .. STREAM=6)
//
// Handshake: on both streams a byte moves on a rising edge where valid and
// ready are both high. The sender holds data and valid stable until that edge;
// valid does not wait on ready, so a byte can move on every cycle.
// -----------------------------------------------------------------------------
module fc_layer_ctrl #(
    parameter int IN_MAX  = 128,
    parameter int OUT_MAX = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   cfg_in_size,
    input  logic [31:0]                   cfg_out_size,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          fc_en,
    output logic [31:0]                   fc_actual_in,
    output logic [31:0]                   fc_actual_out,
    output logic [IN_MAX*8-1:0]           fc_in_vec,
    output logic [OUT_MAX*IN_MAX*8-1:0]   fc_weights,
    output logic [OUT_MAX*8-1:0]          fc_bias,
    input  logic [OUT_MAX*8-1:0]          fc_out_vec,
    input  logic                          fc_valid,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_IN = 3'd1,
        S_LOAD_W  = 3'd2,
        S_LOAD_B  = 3'd3,
        S_COMPUTE = 3'd4,
        S_WAIT    = 3'd5,
        S_STREAM  = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]                 r_in_size;
    logic [31:0]                 r_out_size;
    logic [31:0]                 r_idx;    // byte index for LOAD_IN, LOAD_B and STREAM
    logic [31:0]                 r_row;    // weight row (output neuron)
    logic [31:0]                 r_col;    // weight column (input element)
    logic [IN_MAX*8-1:0]         r_in_vec;
    logic [OUT_MAX*IN_MAX*8-1:0] r_weights;
    logic [OUT_MAX*8-1:0]        r_bias;
    logic [OUT_MAX*8-1:0]        r_result;
    logic                        r_done;
    logic                        r_err;

    logic        w_cfg_ok;
    logic        w_s_fire;
    logic        w_m_fire;
    logic        w_last_in;
    logic        w_last_out;
    logic        w_last_col;
    logic        w_last_row;
    logic [31:0] w_w_idx;

    assign w_cfg_ok   = (cfg_in_size  != 32'd0) && (cfg_in_size  <= 32'(IN_MAX)) &&
                        (cfg_out_size != 32'd0) && (cfg_out_size <= 32'(OUT_MAX));
    assign w_s_fire   = s_valid && s_ready;
    assign w_m_fire   = m_valid && m_ready;
    assign w_last_in  = (r_idx == r_in_size  - 32'd1);
    assign w_last_out = (r_idx == r_out_size - 32'd1);
    assign w_last_col = (r_col == r_in_size  - 32'd1);
    assign w_last_row = (r_row == r_out_size - 32'd1);
    // Rows are laid out at IN_MAX pitch even when the job is narrower, so the
    // datapath always sees weight (r, c) at the same place.
    assign w_w_idx    = r_row * 32'(IN_MAX) + r_col;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start && w_cfg_ok)                     w_next = S_LOAD_IN;
            S_LOAD_IN: if (w_s_fire && w_last_in)                 w_next = S_LOAD_W;
            S_LOAD_W:  if (w_s_fire && w_last_col && w_last_row)  w_next = S_LOAD_B;
            S_LOAD_B:  if (w_s_fire && w_last_out)                w_next = S_COMPUTE;
            S_COMPUTE:                                            w_next = S_WAIT;
            S_WAIT:    if (fc_valid)                              w_next = S_STREAM;
            S_STREAM:  if (w_m_fire && w_last_out)                w_next = S_IDLE;
            default:                                              w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        s_ready = 1'b0;
        fc_en   = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE:                        busy    = 1'b0;
            S_LOAD_IN, S_LOAD_W, S_LOAD_B: s_ready = 1'b1;
            S_COMPUTE:                     fc_en   = 1'b1;
            S_STREAM:                      m_valid = 1'b1;
            default:                       ;
        endcase
    end

    // Buffers, counters and the captured result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_size  <= 32'd0;
            r_out_size <= 32'd0;
            r_idx      <= 32'd0;
            r_row      <= 32'd0;
            r_col      <= 32'd0;
            r_in_vec   <= '0;
            r_weights  <= '0;
            r_bias     <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_cfg_ok) begin
                        r_in_size  <= cfg_in_size;
                        r_out_size <= cfg_out_size;
                        r_idx      <= 32'd0;
                        r_row      <= 32'd0;
                        r_col      <= 32'd0;
                        // Cleared so bytes beyond a short job read as zero.
                        r_in_vec   <= '0;
                        r_weights  <= '0;
                        r_bias     <= '0;
                    end
                end
                S_LOAD_IN: begin
                    if (w_s_fire) begin
                        r_in_vec[r_idx*8 +: 8] <= s_data;
                        r_idx <= w_last_in ? 32'd0 : r_idx + 32'd1;
                    end
                end
                S_LOAD_W: begin
                    if (w_s_fire) begin
                        r_weights[w_w_idx*8 +: 8] <= s_data;
                        if (w_last_col) begin
                            r_col <= 32'd0;
                            r_row <= r_row + 32'd1;
                        end else begin
                            r_col <= r_col + 32'd1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_s_fire) begin
                        r_bias[r_idx*8 +: 8] <= s_data;
                        r_idx <= w_last_out ? 32'd0 : r_idx + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (fc_valid) begin
                        r_result <= fc_out_vec;
                    end
                end
                S_STREAM: begin
                    if (w_m_fire) begin
                        r_idx <= w_last_out ? 32'd0 : r_idx + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single-cycle status pulses, raised in the cycle after the causing edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == S_STREAM) && w_m_fire && w_last_out;
            r_err  <= (r_state == S_IDLE) && start && !w_cfg_ok;
        end
    end

    assign done          = r_done;
    assign err           = r_err;
    assign fc_actual_in  = r_in_size;
    assign fc_actual_out = r_out_size;
    assign fc_in_vec     = r_in_vec;
    assign fc_weights    = r_weights;
    assign fc_bias       = r_bias;
    // r_idx stays put while m_ready is low, so m_data holds with it.
    assign m_data        = (r_state == S_STREAM) ? r_result[r_idx*8 +: 8] : 8'd0;
    assign o_dbg_state   = r_state;

endmodule
